// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width
// and the baud divisor helper used by both uart_rx and uart_tx.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } uart_rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high input.
// Both flops reset to 1 so reset never looks like a start bit.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a single-entry
// valid/ready output buffer that reports overrun and framing errors.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50250000,
    parameter int BAUD     = 115200
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data_o,
    output logic                      data_val_o,
    input  logic                      data_rdy_i,
    output logic                      frame_err_o,
    output logic                      overrun_o
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CW  = $clog2(CPB);

    localparam logic [CW-1:0] CNT_FULL = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);

    logic                      rx_s;
    logic                      prev_q;
    uart_rx_state_t            state_q;
    logic [CW-1:0]             cnt_q;
    logic [2:0]                bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      done_q;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    // Frame FSM; done_q hands a good byte to the buffer one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RX_IDLE;
            prev_q      <= 1'b1;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            prev_q      <= rx_s;
            done_q      <= 1'b0;
            frame_err_o <= 1'b0;
            unique case (state_q)
                RX_IDLE: begin
                    if (prev_q && !rx_s) begin
                        state_q <= RX_START;
                        cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q              <= '0;
                        shift_q[bit_idx_q] <= rx_s;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        if (rx_s) begin
                            done_q <= 1'b1;
                        end else begin
                            frame_err_o <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    // A full buffer being drained this cycle can be refilled without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o     <= '0;
            data_val_o <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (done_q) begin
                if (!data_val_o || data_rdy_i) begin
                    data_o     <= shift_q;
                    data_val_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (data_val_o && data_rdy_i) begin
                data_val_o <= 1'b0;
            end
        end
    end

endmodule
